mult_writeback: RTL

- Writer-side counterpart to the register-file/multiplier datapath. Accepts multiplier results over a valid/ready handshake and buffers them in a small FIFO.
- Drains each result into the register file write port (w_valid/w_addr/w_data) at an auto-incrementing destination address.
- A product wider than one register is written as consecutive register beats, low chunk first.

---
 rtl/mult_writeback_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/mult_writeback.sv | 89 ++++++++
 3 files changed

// File: rtl/mult_writeback_pkg.sv
// Shared defaults and helpers for the multiplier write-back path: result width,
// register geometry and how a product splits into register-sized beats.
package mult_writeback_pkg;

    localparam int DEF_MULT_DATA_WIDTH = 64;
    localparam int DEF_REG_DATA_WIDTH  = 32;
    localparam int DEF_REG_ADDR_WIDTH  = 5;
    localparam int DEF_FIFO_DEPTH      = 4;

    localparam int BEATS       = DEF_MULT_DATA_WIDTH / DEF_REG_DATA_WIDTH;
    localparam bit BEATS_EXACT = (BEATS * DEF_REG_DATA_WIDTH) == DEF_MULT_DATA_WIDTH;

    // A product must split into a whole number (>= 1) of register words.
    function automatic bit split_is_exact(input int mult_w, input int reg_w);
        return (reg_w > 0) && (mult_w >= reg_w) && ((mult_w % reg_w) == 0);
    endfunction

    function automatic int beats_of(input int mult_w, input int reg_w);
        return mult_w / reg_w;
    endfunction

    // Beat counter needs at least one bit even for single-beat products.
    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with an always-visible head entry; pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module sync_fifo
    import mult_writeback_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy, status flags and guarded push/pop strobes.
    always_comb begin
        count     = wr_ptr_r - rd_ptr_r;
        full      = (count == (AW + 1)'(DEPTH));
        empty     = (count == '0);
        head      = mem_r[rd_ptr_r[AW-1:0]];
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Storage and pointers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_writeback.sv
// Buffers multiplier results and drains each one into the register file as
// consecutive low-chunk-first beats at an auto-incrementing address.
module mult_writeback
    import mult_writeback_pkg::*;
#(
    parameter int MULT_DATA_WIDTH = DEF_MULT_DATA_WIDTH,
    parameter int REG_DATA_WIDTH  = DEF_REG_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH  = DEF_REG_ADDR_WIDTH,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           res_valid,
    input  logic [MULT_DATA_WIDTH-1:0]     res_data,
    output logic                           res_ready,
    input  logic                           addr_load,
    input  logic [REG_ADDR_WIDTH-1:0]      base_addr,
    input  logic                           w_stall,
    output logic                           w_valid,
    output logic [REG_ADDR_WIDTH-1:0]      w_addr,
    output logic [REG_DATA_WIDTH-1:0]      w_data,
    output logic                           entry_done,
    output logic                           wrapped,
    output logic [$clog2(FIFO_DEPTH):0]    count
);

    localparam int NUM_BEATS = beats_of(MULT_DATA_WIDTH, REG_DATA_WIDTH);
    localparam int BW        = beat_width(NUM_BEATS);

    if (!split_is_exact(MULT_DATA_WIDTH, REG_DATA_WIDTH)) begin : g_width_check
        $error("mult_writeback: MULT_DATA_WIDTH must be a whole multiple of REG_DATA_WIDTH");
    end

    logic [MULT_DATA_WIDTH-1:0] head_s;
    logic                       full_s;
    logic                       empty_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       last_beat_s;
    logic [BW-1:0]              beat_r;
    logic [REG_ADDR_WIDTH-1:0]  ptr_r;

    sync_fifo #(
        .WIDTH (MULT_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (res_data),
        .head  (head_s),
        .count (count),
        .full  (full_s),
        .empty (empty_s)
    );

    // Write port is driven straight from the head entry so a result pushed at
    // one edge is written in the very next cycle; no bypass when full.
    always_comb begin
        res_ready   = !full_s;
        push_s      = res_valid && !full_s;
        w_valid     = !empty_s && !w_stall;
        w_addr      = ptr_r;
        w_data      = head_s[beat_r*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        last_beat_s = (beat_r == BW'(NUM_BEATS - 1));
        pop_s       = w_valid && last_beat_s;
        entry_done  = pop_s;
        wrapped     = w_valid && (ptr_r == '1);
    end

    // Address pointer (load overrides increment) and beat position in the head entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r  <= '0;
            beat_r <= '0;
        end else begin
            if (addr_load) begin
                ptr_r <= base_addr;
            end else if (w_valid) begin
                ptr_r <= ptr_r + 1'b1;
            end
            if (w_valid) begin
                beat_r <= last_beat_s ? '0 : beat_r + 1'b1;
            end
        end
    end

endmodule
